param_wrr_arbiter: RTL and testbench

PARAM_WRR_ARBITER -- requirements
Module: param_wrr_arbiter

---
 rtl/param_wrr_arbiter_pkg.sv | 30 +++
 rtl/param_wrr_arbiter_pick.sv | 31 +++
 rtl/param_wrr_arbiter.sv | 110 +++++++++++
 tb/tb_param_wrr_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/param_wrr_arbiter_pkg.sv
// Shared constants, decision encoding and one-hot decode for the weighted round-robin arbiter.
// Used by param_wrr_arbiter (optional lock input enabled by WRR_LOCK_EN).
package wrr_arb_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_WEIGHT_W = 2;

   // Upper bound of supported requesters; the decoder below is sized for it.
   localparam int MAX_N     = 16;
   localparam int MAX_IDX_W = 4;

   typedef enum logic [1:0] {
      DEC_ARB  = 2'd0,
      DEC_HOLD = 2'd1,
      DEC_LOCK = 2'd2
   } arb_dec_e;

   // OR-reduction decode: exact for one-hot input, 0 for all-zero input.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/param_wrr_arbiter_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping modulo N.
module rr_priority_pick
   import wrr_arb_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     winner,
   output logic             found
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/param_wrr_arbiter.sv
// Weighted round-robin arbiter: grant/credit/ptr registers and the hold/re-arbitrate decision.
// Defining WRR_LOCK_EN adds a lock input that pins the current holder without spending credit.
module param_wrr_arbiter
   import wrr_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int WEIGHT_W = DEF_WEIGHT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N*WEIGHT_W-1:0] weight,
`ifdef WRR_LOCK_EN
   input  logic [N-1:0]          lock,
`endif
   output logic [N-1:0]          grant,
   output logic                  grant_valid,
   output logic [$clog2(N)-1:0]  grant_id
);

   localparam int IDX_W = $clog2(N);

   logic [N-1:0]         r_grant;
   logic [WEIGHT_W-1:0]  r_credit;
   logic [IDX_W-1:0]     r_ptr;

   logic [MAX_IDX_W-1:0] w_holder_idx16;
   logic [MAX_IDX_W-1:0] w_win_idx16;
   logic [IDX_W-1:0]     w_holder_id;
   logic [IDX_W-1:0]     w_win_id;
   logic [IDX_W-1:0]     w_ptr_next;
   logic [N-1:0]         w_win;
   logic                 w_found;
   logic                 w_holder_req;
   logic                 w_others;
   logic                 w_locked;
   logic [WEIGHT_W-1:0]  w_win_weight;
   arb_dec_e             w_dec;

   rr_priority_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .winner (w_win),
      .found  (w_found)
   );

   assign w_holder_idx16 = onehot_to_idx(MAX_N'(r_grant));
   assign w_win_idx16    = onehot_to_idx(MAX_N'(w_win));
   assign w_holder_id    = w_holder_idx16[IDX_W-1:0];
   assign w_win_id       = w_win_idx16[IDX_W-1:0];

   assign w_holder_req = (|r_grant) & req[w_holder_id];
   assign w_others     = |(req & ~r_grant);
   assign w_win_weight = weight[int'(w_win_id)*WEIGHT_W +: WEIGHT_W];
   assign w_ptr_next   = (w_win_id == IDX_W'(N-1)) ? '0 : w_win_id + IDX_W'(1);

`ifdef WRR_LOCK_EN
   assign w_locked = w_holder_req & lock[w_holder_id];
`else
   assign w_locked = 1'b0;
`endif

   // A lone holder keeps the grant even with no credit left.
   always_comb begin
      w_dec = DEC_ARB;
      if (w_locked) begin
         w_dec = DEC_LOCK;
      end else if (w_holder_req && ((r_credit != '0) || !w_others)) begin
         w_dec = DEC_HOLD;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant  <= '0;
         r_credit <= '0;
         r_ptr    <= '0;
      end else begin
         case (w_dec)
            DEC_LOCK: begin
               r_credit <= r_credit;
            end
            DEC_HOLD: begin
               if (r_credit != '0) begin
                  r_credit <= r_credit - WEIGHT_W'(1);
               end
            end
            default: begin
               if (w_found) begin
                  r_grant  <= w_win;
                  r_credit <= w_win_weight;
                  r_ptr    <= w_ptr_next;
               end else begin
                  r_grant  <= '0;
                  r_credit <= '0;
               end
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_valid = |r_grant;
   assign grant_id    = w_holder_id;

endmodule

// File: tb/tb_param_wrr_arbiter.sv
// Scoreboard bench for param_wrr_arbiter (N=4, WEIGHT_W=2); lock scenario when WRR_LOCK_EN is defined.
module tb_param_wrr_arbiter;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] id;
      string      name;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [7:0] weight;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
`ifdef WRR_LOCK_EN
   logic [3:0] lock;
   logic [3:0] lock_nxt;
`endif

   exp_t exp_q[$];
   int   n_checks;
   int   n_fail;

   param_wrr_arbiter #(
      .N        (4),
      .WEIGHT_W (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .weight      (weight),
`ifdef WRR_LOCK_EN
      .lock        (lock),
`endif
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs for the next edge and queue the grant that edge must produce.
   task automatic step(input logic [3:0] r, input logic [7:0] w, input logic [3:0] eg,
                       input logic [1:0] eid, input string nm);
      exp_t e;
      @(negedge clk);
      req    = r;
      weight = w;
`ifdef WRR_LOCK_EN
      lock   = lock_nxt;
`endif
      e.grant = eg;
      e.id    = eid;
      e.name  = nm;
      exp_q.push_back(e);
   endtask

   task automatic step_n(input int n, input logic [3:0] r, input logic [7:0] w,
                         input logic [3:0] eg, input logic [1:0] eid, input string nm);
      for (int i = 0; i < n; i++) begin
         step(r, w, eg, eid, $sformatf("%s_%0d", nm, i));
      end
   endtask

   // Monitor: compares every registered output against the oldest queued expectation.
   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({e.name, "_grant"}, 32'(grant), 32'(e.grant));
            check({e.name, "_valid"}, 32'(grant_valid), 32'(e.grant != 4'b0000));
            check({e.name, "_id"}, 32'(grant_id), 32'(e.id));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      req      = 4'b0000;
      weight   = 8'h00;
`ifdef WRR_LOCK_EN
      lock     = 4'b0000;
      lock_nxt = 4'b0000;
`endif
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      check("reset_grant", 32'(grant), 32'h0);
      check("reset_valid", 32'(grant_valid), 32'h0);
      check("reset_id", 32'(grant_id), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Plain round robin between requesters 1 and 2.
      step(4'b0110, 8'h00, 4'b0010, 2'd1, "rr_a");
      step(4'b0110, 8'h00, 4'b0100, 2'd2, "rr_b");
      step(4'b0110, 8'h00, 4'b0010, 2'd1, "rr_c");
      step(4'b0110, 8'h00, 4'b0100, 2'd2, "rr_d");
      step(4'b0000, 8'h00, 4'b0000, 2'd0, "idle_keep_ptr");

      // Weights {3,0,1,0}; pointer left at 3 by the idle edge.
      step_n(4, 4'b1111, 8'hC4, 4'b1000, 2'd3, "wrr_r3");
      step(4'b1111, 8'hC4, 4'b0001, 2'd0, "wrr_r0");
      step_n(2, 4'b1111, 8'hC4, 4'b0010, 2'd1, "wrr_r1");
      step(4'b1111, 8'hC4, 4'b0100, 2'd2, "wrr_r2");
      step_n(4, 4'b1111, 8'hC4, 4'b1000, 2'd3, "wrr_r3b");
      step(4'b1111, 8'hC4, 4'b0001, 2'd0, "wrr_r0b");

      // Holder drops mid-burst, weight changes mid-burst, pointer wraps.
      step(4'b0000, 8'h00, 4'b0000, 2'd0, "idle2");
      step(4'b0001, 8'h03, 4'b0001, 2'd0, "load_w3");
      step(4'b0100, 8'h13, 4'b0100, 2'd2, "drop_no_gap");
      step(4'b1100, 8'h30, 4'b0100, 2'd2, "weight_change_ignored");
      step(4'b1100, 8'h30, 4'b1000, 2'd3, "burst_ends");
      step(4'b0011, 8'h30, 4'b0001, 2'd0, "ptr_wrap");
      step(4'b0000, 8'h30, 4'b0000, 2'd0, "all_idle");

      // Asynchronous reset in the middle of requester 2's burst.
      step(4'b1111, 8'h00, 4'b0010, 2'd1, "pre_reset_a");
      step(4'b1111, 8'h20, 4'b0100, 2'd2, "pre_reset_b");
      @(posedge clk);
      #3;
      rst    = 1'b0;
      req    = 4'b0000;
      weight = 8'h00;
      #1;
      check("async_reset_grant", 32'(grant), 32'h0);
      check("async_reset_valid", 32'(grant_valid), 32'h0);
      check("async_reset_id", 32'(grant_id), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(4'b1111, 8'h01, 4'b0001, 2'd0, "post_reset_from_0");
      step(4'b1111, 8'h01, 4'b0001, 2'd0, "post_reset_hold");
      step(4'b1111, 8'h01, 4'b0010, 2'd1, "post_reset_next");

`ifdef WRR_LOCK_EN
      lock_nxt = 4'b0010;
      step_n(3, 4'b1111, 8'h00, 4'b0010, 2'd1, "locked");
      lock_nxt = 4'b0000;
      step(4'b1111, 8'h00, 4'b0100, 2'd2, "unlocked");
`endif

      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
